// File: rtl/inst_encoder_pkg.sv
// inst_encoder_pkg: format/error/state codes and immediate range helpers shared by the encoder.
// The range helpers are only referenced when INST_ENCODER_RANGE_CHECK_EN is defined.
package inst_encoder_pkg;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_CSR, FMT_RSVD} fmt_e;
    typedef enum logic [1:0] {ERR_NONE, ERR_IMM, ERR_FMT, ERR_WRAP} err_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE, ST_ERR} state_e;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct packed {
        logic [2:0]  fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        last;
    } beat_t;

    // True when v is a sign extension of its low msb bits.
    function automatic logic fits(input logic [31:0] v, input int unsigned msb);
        logic [31:0] h;
        h = 32'($signed(v) >>> msb);
        return &h | ~|h;
    endfunction

    function automatic logic imm_ok(input logic [2:0] fmt, input logic [31:0] imm);
        return fmt == FMT_I || fmt == FMT_S ? fits(imm, 11)
             : fmt == FMT_B ? fits(imm, 12) & ~imm[0]
             : fmt == FMT_J ? fits(imm, 20) & ~imm[0]
             : fmt == FMT_U ? ~|imm[11:0]
             : fmt == FMT_CSR ? ~|imm[31:12]
             : 1'b1;
    endfunction

endpackage

// File: rtl/inst_encoder_imm_pack.sv
// imm_pack: combinational packing of decoded RV32I fields into a 32-bit instruction word.
// Out-of-range immediates are truncated to the bits each format carries.
module imm_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word
);

    // Only OP-IMM shifts carry funct7; loads share funct3 001/101 but keep a full offset.
    logic shift;
    assign shift = opcode == OP_IMM && (funct3 == 3'b001 || funct3 == 3'b101);

    always_comb begin
        word = fmt == FMT_R ? {funct7, rs2, rs1, funct3, rd, opcode}
             : fmt == FMT_I && shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode}
             : fmt == FMT_I || fmt == FMT_CSR ? {imm[11:0], rs1, funct3, rd, opcode}
             : fmt == FMT_S ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
             : fmt == FMT_B ? {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
             : fmt == FMT_U ? {imm[31:12], rd, opcode}
             : fmt == FMT_J ? {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
             : {25'd0, opcode};
    end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streams decoded fields into packed RV32I words at sequential IMEM addresses.
// Define INST_ENCODER_RANGE_CHECK_EN to flag out-of-range immediates (err_code 1).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int IMEM_AW   = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    input  logic               in_last,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [31:0]        inst_data,
    output logic [IMEM_AW-1:0] inst_addr,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);

    state_e      state, state_nx;
    beat_t       s1, in_beat;
    logic        s1_valid, s2_last;
    logic        out_fire, wrap_err, s1_advance, beat, fmt_err, range_err, beat_err, start_ok, go_err;
    logic [31:0] pack_word;

    assign in_beat = {in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, in_last};
    assign out_fire = inst_valid & inst_ready;
    // Leaving the top address with beats still to come would overwrite the program start.
    assign wrap_err = state == ST_RUN && out_fire && &inst_addr && !s2_last;
    assign s1_advance = s1_valid & (~inst_valid | inst_ready) & ~wrap_err;
    assign beat = in_valid & in_ready;
    assign fmt_err = in_fmt == FMT_RSVD;
`ifdef INST_ENCODER_RANGE_CHECK_EN
    assign range_err = ~imm_ok(in_fmt, in_imm);
`else
    assign range_err = 1'b0;
`endif
    assign beat_err = beat & (fmt_err | range_err);
    assign start_ok = start & (state == ST_IDLE || state == ST_ERR);
    assign go_err = state == ST_RUN && state_nx == ST_ERR;

    imm_pack u_pack (
        .fmt    (s1.fmt),
        .opcode (s1.opcode),
        .rd     (s1.rd),
        .rs1    (s1.rs1),
        .rs2    (s1.rs2),
        .funct3 (s1.funct3),
        .funct7 (s1.funct7),
        .imm    (s1.imm),
        .word   (pack_word)
    );

    always_ff @(posedge clk) begin
        state <= !rst ? ST_IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = out_fire && s2_last ? ST_DONE : wrap_err || beat_err ? ST_ERR : ST_RUN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = start ? ST_RUN : ST_ERR;
        endcase
    end

    always_comb begin
        in_ready = state == ST_RUN && (!s1_valid || s1_advance);
        done = state == ST_DONE;
    end

    // A rejected beat never enters S1; a wrap drops whatever S1 holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid   <= 1'b0;
            s1         <= '0;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            s2_last    <= 1'b0;
            inst_addr  <= BASE;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            s1_valid   <= start_ok || wrap_err ? 1'b0 : beat && !beat_err ? 1'b1 : s1_advance ? 1'b0 : s1_valid;
            s1         <= beat ? in_beat : s1;
            inst_valid <= start_ok ? 1'b0 : s1_advance ? 1'b1 : out_fire ? 1'b0 : inst_valid;
            inst_data  <= s1_advance ? pack_word : inst_data;
            s2_last    <= s1_advance ? s1.last : s2_last;
            inst_addr  <= start_ok ? BASE : out_fire ? inst_addr + 1'b1 : inst_addr;
            err        <= start_ok ? 1'b0 : go_err ? 1'b1 : err;
            err_code   <= start_ok ? ERR_NONE : !go_err ? err_code : wrap_err ? ERR_WRAP : fmt_err ? ERR_FMT : ERR_IMM;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: directed and randomized programs checked against an arithmetic packing model.
module tb_inst_encoder;

    logic        clk = 0, rst = 0, start = 0, in_valid = 0, in_last = 0, inst_ready = 0;
    logic [2:0]  in_fmt = 0, in_funct3 = 0;
    logic [6:0]  in_opcode = 0, in_funct7 = 0;
    logic [4:0]  in_rd = 0, in_rs1 = 0, in_rs2 = 0;
    logic [31:0] in_imm = 0;
    logic        in_ready, inst_valid, done, err;
    logic [31:0] inst_data;
    logic [1:0]  inst_addr, err_code;

    int n_pass = 0, n_checks = 0;

    always #5 clk = ~clk;

    inst_encoder #(.IMEM_AW(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_addr(inst_addr), .done(done), .err(err), .err_code(err_code)
    );

    typedef struct {
        int unsigned fmt, op, rd, rs1, rs2, f3, f7, imm;
    } ins_t;

    ins_t        prog[$];
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Bit placement written as field arithmetic from the RV32I encoding tables.
    function automatic logic [31:0] model_pack(input ins_t b);
        int unsigned i = b.imm;
        int unsigned ri = b.op + (b.rd << 7) + (b.f3 << 12) + (b.rs1 << 15);
        int unsigned rs = b.op + (b.f3 << 12) + (b.rs1 << 15) + (b.rs2 << 20);
        case (b.fmt)
            0: return ri + (b.rs2 << 20) + (b.f7 << 25);
            1: return b.op == 19 && (b.f3 == 1 || b.f3 == 5) ? ri + ((i % 32) << 20) + (b.f7 << 25)
                                                             : ri + ((i % 4096) << 20);
            2: return rs + ((i % 32) << 7) + (((i >> 5) % 128) << 25);
            3: return rs + (((i >> 1) % 16) << 8) + (((i >> 11) % 2) << 7) + (((i >> 5) % 64) << 25) + (((i >> 12) % 2) << 31);
            4: return b.op + (b.rd << 7) + ((i >> 12) << 12);
            5: return b.op + (b.rd << 7) + (((i >> 12) % 256) << 12) + (((i >> 11) % 2) << 20) + (((i >> 1) % 1024) << 21) + (((i >> 20) % 2) << 31);
            6: return ri + ((i % 4096) << 20);
            default: return b.op;
        endcase
    endfunction

    task automatic push(input int f, input int op, input int rd, input int rs1, input int rs2, input int f3, input int f7, input int imm);
        ins_t t;
        t.fmt = f; t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.f3 = f3; t.f7 = f7; t.imm = imm;
        prog.push_back(t);
    endtask

    task automatic push_rand();
        int f = $urandom_range(0, 6);
        bit e = $urandom_range(0, 3) == 0;
        int v;
        int op;
        case (f)
            0: begin op = 'h33; v = $urandom; end
            1: begin op = $urandom_range(0, 2) == 0 ? 'h03 : $urandom_range(0, 1) ? 'h67 : 'h13;
                     v = e ? ($urandom_range(0, 1) ? 2047 : -2048) : int'($urandom_range(0, 4095)) - 2048; end
            2: begin op = 'h23; v = e ? ($urandom_range(0, 1) ? 2047 : -2048) : int'($urandom_range(0, 4095)) - 2048; end
            3: begin op = 'h63; v = e ? ($urandom_range(0, 1) ? 4094 : -4096) : (int'($urandom_range(0, 4095)) - 2048) * 2; end
            4: begin op = $urandom_range(0, 1) ? 'h37 : 'h17; v = $urandom & 32'hFFFFF000; end
            5: begin op = 'h6F; v = e ? ($urandom_range(0, 1) ? 1048574 : -1048576) : (int'($urandom_range(0, 1048575)) - 524288) * 2; end
            default: begin op = 'h73; v = $urandom_range(0, 4095); end
        endcase
        push(f, op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 7), $urandom_range(0, 127), v);
    endtask

    function automatic void model_all(input int count);
        for (int k = 0; k < count; k++) exp_q.push_back(model_pack(prog[k]));
    endfunction

    // mode 0: free flowing, 1: random bubbles and backpressure, 2: 5-cycle stall after the first word.
    task automatic run_prog(input int mode, input int exp_code);
        int n = prog.size();
        int nexp = exp_q.size();
        int bi = 0, wi = 0, cyc = 0, post = 0, stall = 0, done_cnt = 0;
        int first_beat = -1, first_val = -1, first_fire = -1, last_fire = -1;
        bit fin = 0, last_prev = 0;
        @(negedge clk);
        start = 1; in_valid = 0; inst_ready = 1;
        @(negedge clk);
        start = 0;
        #1;
        chk("start_err", err, 0);
        chk("start_addr", inst_addr, 0);
        chk("start_in_ready", in_ready, 1);
        while (!(fin && post == 3) && cyc < 400) begin
            @(negedge clk);
            in_valid = bi < n && (mode != 1 || $urandom_range(0, 3) != 0);
            if (bi < n) begin
                in_fmt = 3'(prog[bi].fmt); in_opcode = 7'(prog[bi].op); in_rd = 5'(prog[bi].rd);
                in_rs1 = 5'(prog[bi].rs1); in_rs2 = 5'(prog[bi].rs2); in_funct3 = 3'(prog[bi].f3);
                in_funct7 = 7'(prog[bi].f7); in_imm = prog[bi].imm; in_last = bi == n - 1;
            end
            inst_ready = mode == 1 ? $urandom_range(0, 2) != 0 : !(mode == 2 && wi == 1 && inst_valid && stall < 5);
            if (mode == 2 && !inst_ready) stall++;
            #1;
            if (mode == 2 && !inst_ready && stall >= 2 && bi < n) chk("stall_in_ready", in_ready, 0);
            if (inst_valid) begin
                if (first_val < 0) first_val = cyc;
                if (wi < nexp) begin
                    chk("inst_data", inst_data, exp_q[wi]);
                    chk("inst_addr", inst_addr, wi % 4);
                end else chk("extra_word", inst_valid, 0);
            end
            if (done) begin
                done_cnt++;
                chk("done_timing", last_prev, 1);
                chk("done_in_ready", in_ready, 0);
            end
            last_prev = inst_valid && inst_ready && wi == nexp - 1 && exp_code == 0;
            if (in_valid && in_ready) begin
                if (first_beat < 0) first_beat = cyc;
                bi++;
            end
            if (inst_valid && inst_ready) begin
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                wi++;
            end
            if (fin) post++;
            else fin = wi == nexp && (exp_code == 0 ? done_cnt > 0 : err);
            cyc++;
        end
        in_valid = 0;
        chk("timeout", fin, 1);
        chk("word_count", wi, nexp);
        chk("done_count", done_cnt, exp_code == 0);
        chk("err", err, exp_code != 0);
        chk("err_code", err_code, exp_code);
        chk("latency", first_val - first_beat, 2);
        if (mode == 0 && exp_code == 0) chk("throughput", last_fire - first_fire, nexp - 1);
        prog.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 0; in_valid = 1; inst_ready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_inst_data", inst_data, 0);
        chk("rst_inst_addr", inst_addr, 0);
        rst = 1;
        @(negedge clk);
        #1;
        chk("idle_in_ready", in_ready, 0);
        in_valid = 0;

        push(1, 'h13, 0, 0, 0, 0, 0, 2);
        push(1, 'h67, 1, 2, 0, 0, 0, 8);
        push(0, 'h33, 2, 1, 3, 0, 0, 0);
        exp_q = '{32'h00200013, 32'h008100E7, 32'h00308133};
        run_prog(0, 0);

        push(5, 'h6F, 1, 0, 0, 0, 0, 8);
        push(3, 'h63, 0, 2, 3, 0, 0, 16);
        push(3, 'h63, 0, 2, 3, 6, 0, 32);
        push(2, 'h23, 0, 2, 1, 2, 0, 4);
        exp_q = '{32'h008000EF, 32'h00310863, 32'h02316063, 32'h00112223};
        run_prog(0, 0);

        repeat (4) push_rand();
        model_all(4);
        run_prog(2, 0);

        push(1, 'h13, 5, 6, 0, 0, 0, 100);
        push(3, 'h63, 0, 2, 3, 0, 0, 3);
        push(1, 'h13, 7, 8, 0, 0, 0, -1);
`ifdef INST_ENCODER_RANGE_CHECK_EN
        model_all(1);
        run_prog(0, 1);
`else
        model_all(3);
        run_prog(0, 0);
`endif

        push(1, 'h13, 5, 6, 0, 0, 0, 7);
        push(7, 'h13, 1, 1, 1, 0, 0, 0);
        push(1, 'h13, 7, 8, 0, 0, 0, 9);
        model_all(1);
        run_prog(0, 2);

        repeat (5) push_rand();
        model_all(4);
        run_prog(0, 3);

        repeat (6) push_rand();
        model_all(4);
        run_prog(1, 3);

        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0; in_valid = 1; in_fmt = 1; in_opcode = 'h13; in_imm = 5; in_last = 0; inst_ready = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_valid", inst_valid, 1);
        rst = 0;
        @(negedge clk);
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_inst_valid", inst_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_inst_data", inst_data, 0);
        chk("mid_rst_inst_addr", inst_addr, 0);
        rst = 1; in_valid = 0;

        for (int p = 0; p < 20; p++) begin
            int len = $urandom_range(1, 4);
            repeat (len) push_rand();
            model_all(len);
            run_prog($urandom_range(0, 2), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
